// File: rtl/game_pkg.sv
// Shared constants and types for the Arduino->FPGA game link.
// Holds packet framing, screen geometry and the decoder FSM encoding.
package game_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int unsigned PKT_LEN = 7;
  localparam int unsigned SCR_W = 800;
  localparam int unsigned SCR_H = 600;
  localparam int unsigned COORD_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ID   = 3'd1,
    ST_XH   = 3'd2,
    ST_XL   = 3'd3,
    ST_YH   = 3'd4,
    ST_YL   = 3'd5,
    ST_CSUM = 3'd6
  } pkt_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/player_pkt_decoder.sv
// Decodes 7-byte SYNC/ID/XH/XL/YH/YL/CSUM packets into one-cycle player position writes.
// Write strobe follows the CSUM byte by one cycle; no backpressure, one byte per rx_valid.
module player_pkt_decoder #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MAX_X          = 799,
  parameter int unsigned MAX_Y          = 599,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       pos_wr_en,
  output logic [2:0] pos_idx,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [7:0] ok_cnt,
  output logic [7:0] err_cnt,
  output logic       busy
);

  import game_pkg::*;

  localparam logic [COORD_W-1:0] MAX_X_C = COORD_W'(MAX_X);
  localparam logic [COORD_W-1:0] MAX_Y_C = COORD_W'(MAX_Y);
  localparam logic [17:0]        TMO_C   = 18'(TIMEOUT_CYCLES);

  pkt_state_t         state_q;
  logic [17:0]        timer_q;
  logic [7:0]         csum_q;
  logic               rsv_q;
  logic [2:0]         idx_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;

  logic               pos_wr_en_q;
  logic [2:0]         pos_idx_q;
  logic [COORD_W-1:0] pos_x_q;
  logic [COORD_W-1:0] pos_y_q;
  logic [7:0]         ok_cnt_q;
  logic [7:0]         err_cnt_q;

  logic pkt_ok_d;
  logic timeout_d;

  // Fields are complete once the CSUM byte is on the bus; only the checksum compare uses it.
  always_comb begin
    pkt_ok_d  = (csum_q == rx_data) && !rsv_q && (x_q <= MAX_X_C) && (y_q <= MAX_Y_C);
    timeout_d = (state_q != ST_IDLE) && (timer_q == TMO_C);
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      csum_q      <= '0;
      rsv_q       <= 1'b0;
      idx_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pos_wr_en_q <= 1'b0;
      pos_idx_q   <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      ok_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      pos_wr_en_q <= 1'b0;
      if (rx_valid) begin
        // A byte landing on the timeout cycle still counts, so the byte path is checked first.
        timer_q <= '0;
        case (state_q)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) state_q <= ST_ID;
          end
          ST_ID: begin
            csum_q  <= rx_data;
            rsv_q   <= |rx_data[7:3];
            idx_q   <= rx_data[2:0];
            state_q <= ST_XH;
          end
          ST_XH: begin
            csum_q   <= csum_q ^ rx_data;
            rsv_q    <= rsv_q | (|rx_data[7:2]);
            x_q[9:8] <= rx_data[1:0];
            state_q  <= ST_XL;
          end
          ST_XL: begin
            csum_q   <= csum_q ^ rx_data;
            x_q[7:0] <= rx_data;
            state_q  <= ST_YH;
          end
          ST_YH: begin
            csum_q   <= csum_q ^ rx_data;
            rsv_q    <= rsv_q | (|rx_data[7:2]);
            y_q[9:8] <= rx_data[1:0];
            state_q  <= ST_YL;
          end
          ST_YL: begin
            csum_q   <= csum_q ^ rx_data;
            y_q[7:0] <= rx_data;
            state_q  <= ST_CSUM;
          end
          ST_CSUM: begin
            state_q <= ST_IDLE;
            if (pkt_ok_d) begin
              pos_wr_en_q <= 1'b1;
              pos_idx_q   <= idx_q;
              pos_x_q     <= x_q;
              pos_y_q     <= y_q;
              ok_cnt_q    <= sat_inc8(ok_cnt_q);
            end else begin
              err_cnt_q <= sat_inc8(err_cnt_q);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (timeout_d) begin
        state_q   <= ST_IDLE;
        timer_q   <= '0;
        err_cnt_q <= sat_inc8(err_cnt_q);
      end else if (state_q != ST_IDLE) begin
        timer_q <= timer_q + 18'd1;
      end
    end
  end

  assign pos_wr_en = pos_wr_en_q;
  assign pos_idx   = pos_idx_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign ok_cnt    = ok_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_player_pkt_decoder.sv
// Directed bench for player_pkt_decoder with a shortened inter-byte timeout.
module tb_player_pkt_decoder;

  localparam int unsigned TMO = 1000;

  logic       clk50;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       pos_wr_en;
  logic [2:0] pos_idx;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [7:0] ok_cnt;
  logic [7:0] err_cnt;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;

  player_pkt_decoder #(
    .SYNC_BYTE     (8'hA5),
    .MAX_X         (799),
    .MAX_Y         (599),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk50    (clk50),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .pos_wr_en(pos_wr_en),
    .pos_idx  (pos_idx),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .ok_cnt   (ok_cnt),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  always @(negedge clk50) if (pos_wr_en === 1'b1) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic put_byte(input logic [7:0] b);
    @(negedge clk50);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle_cycle();
    @(negedge clk50);
    rx_valid = 1'b0;
  endtask

  // csum_flip is XORed into the correct checksum so a non-zero value forces a bad packet.
  task automatic send_pos(input logic [7:0] id, input logic [9:0] x, input logic [9:0] y,
                          input logic [7:0] csum_flip, input bit end_idle);
    logic [7:0] xh, xl, yh, yl;
    xh = {6'b0, x[9:8]};
    xl = x[7:0];
    yh = {6'b0, y[9:8]};
    yl = y[7:0];
    put_byte(8'hA5);
    put_byte(id);
    put_byte(xh);
    put_byte(xl);
    put_byte(yh);
    put_byte(yl);
    put_byte(id ^ xh ^ xl ^ yh ^ yl ^ csum_flip);
    if (end_idle) idle_cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr"},   32'(pos_wr_en), 0);
    check({tag, "_idx"},  32'(pos_idx), 0);
    check({tag, "_x"},    32'(pos_x), 0);
    check({tag, "_y"},    32'(pos_y), 0);
    check({tag, "_ok"},   32'(ok_cnt), 0);
    check({tag, "_err"},  32'(err_cnt), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int wr0;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk50);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Reference packet: A5 03 01 2C 01 0A 25 -> idx 3, X=300, Y=266.
    send_pos(8'h03, 10'd300, 10'd266, 8'h00, 1'b1);
    check("t1_wr",  32'(pos_wr_en), 1);
    check("t1_idx", 32'(pos_idx), 3);
    check("t1_x",   32'(pos_x), 300);
    check("t1_y",   32'(pos_y), 266);
    check("t1_ok",  32'(ok_cnt), 1);
    @(negedge clk50);
    check("t1_wr_drop", 32'(pos_wr_en), 0);
    check("t1_pulses",  32'(wr_cnt), 1);

    // Same packet with CSUM forced to 00.
    send_pos(8'h03, 10'd300, 10'd266, 8'h25, 1'b1);
    check("t2_wr",  32'(pos_wr_en), 0);
    check("t2_err", 32'(err_cnt), 1);
    check("t2_x",   32'(pos_x), 300);
    check("t2_y",   32'(pos_y), 266);
    check("t2_idx", 32'(pos_idx), 3);

    // Range edges: X=800 rejected, (799,599) accepted, reserved ID bit rejected.
    send_pos(8'h01, 10'd800, 10'd0, 8'h00, 1'b1);
    check("t3_err", 32'(err_cnt), 2);
    check("t3_x",   32'(pos_x), 300);
    send_pos(8'h01, 10'd0, 10'd600, 8'h00, 1'b1);
    check("t3_err_y", 32'(err_cnt), 3);
    send_pos(8'h07, 10'd799, 10'd599, 8'h00, 1'b1);
    check("t3_max_wr", 32'(pos_wr_en), 1);
    check("t3_max_x",  32'(pos_x), 799);
    check("t3_max_y",  32'(pos_y), 599);
    check("t3_max_ok", 32'(ok_cnt), 2);
    send_pos(8'h0B, 10'd10, 10'd10, 8'h00, 1'b1);
    check("t3_rsv_err", 32'(err_cnt), 4);
    check("t3_rsv_idx", 32'(pos_idx), 7);

    // Timeout after A5 05.
    put_byte(8'hA5);
    put_byte(8'h05);
    idle_cycle();
    check("t4_busy", 32'(busy), 1);
    repeat (TMO - 5) @(negedge clk50);
    check("t4_busy_pre", 32'(busy), 1);
    repeat (10) @(negedge clk50);
    check("t4_busy_post", 32'(busy), 0);
    check("t4_err", 32'(err_cnt), 5);
    send_pos(8'h05, 10'd123, 10'd45, 8'h00, 1'b1);
    check("t4_after_ok", 32'(ok_cnt), 3);
    check("t4_after_x",  32'(pos_x), 123);

    // A byte arriving exactly on the timeout cycle wins.
    put_byte(8'hA5);
    repeat (TMO) idle_cycle();
    put_byte(8'h02);
    put_byte(8'h00);
    put_byte(8'h40);
    put_byte(8'h00);
    put_byte(8'h20);
    put_byte(8'h02 ^ 8'h40 ^ 8'h20);
    idle_cycle();
    check("t4_race_err", 32'(err_cnt), 5);
    check("t4_race_ok",  32'(ok_cnt), 4);
    check("t4_race_x",   32'(pos_x), 64);

    // Noise in IDLE, then back-to-back packets.
    put_byte(8'h00);
    put_byte(8'hFF);
    put_byte(8'h12);
    idle_cycle();
    check("t5_noise_busy", 32'(busy), 0);
    wr0 = wr_cnt;
    send_pos(8'h01, 10'd1, 10'd2, 8'h00, 1'b1);
    check("t5_noise_err", 32'(err_cnt), 5);
    check("t5_ok", 32'(ok_cnt), 5);
    send_pos(8'h02, 10'd20, 10'd30, 8'h00, 1'b0);
    send_pos(8'h04, 10'd40, 10'd50, 8'h00, 1'b1);
    @(negedge clk50);
    check("t5_pulses", 32'(wr_cnt - wr0), 3);
    check("t5_b2b_ok", 32'(ok_cnt), 7);
    check("t5_b2b_idx", 32'(pos_idx), 4);
    check("t5_b2b_y",   32'(pos_y), 50);

    // Reset in the middle of a packet.
    put_byte(8'hA5);
    put_byte(8'h02);
    put_byte(8'h00);
    put_byte(8'h10);
    @(negedge clk50);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_all_zero("t6_rst");
    @(negedge clk50);
    rst_n = 1'b1;
    send_pos(8'h02, 10'd16, 10'd5, 8'h00, 1'b1);
    check("t6_ok",  32'(ok_cnt), 1);
    check("t6_x",   32'(pos_x), 16);
    check("t6_idx", 32'(pos_idx), 2);

    for (int i = 0; i < 300; i++) send_pos(8'h01, 10'(i), 10'd7, 8'h00, 1'b0);
    idle_cycle();
    check("t6_sat_ok",  32'(ok_cnt), 255);
    check("t6_sat_err", 32'(err_cnt), 0);
    check("t6_sat_x",   32'(pos_x), 299);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
